// File: rtl/i2s_capture.sv
// I2S master receiver: derives SCK/WS from clk and deserializes one slot into a
// parallel sample with a single-cycle ready strobe.
module i2s_capture #(
  parameter int SCK_HALF_PERIOD = 16,
  parameter int DATA_WIDTH      = 16,
  parameter int CHANNEL         = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  i2s_clk,
  output logic                  i2s_ws,
  input  logic                  i2s_sd,
  output logic [DATA_WIDTH-1:0] pcm_out,
  output logic                  ready
);

  localparam int               DIV_W    = $clog2(SCK_HALF_PERIOD);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_HALF_PERIOD - 1);
  localparam logic [4:0]       LAST_BIT = 5'(DATA_WIDTH);
  localparam logic             SLOT     = 1'(CHANNEL);

  logic [DIV_W-1:0]      div_cnt;
  logic                  sck;
  logic [5:0]            bit_cnt;
  logic [5:0]            bit_cnt_nxt;
  logic [1:0]            sd_pipe;
  logic                  sd_sync;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  terminal;
  logic                  rise_ev;
  logic                  fall_ev;
  logic                  in_slot;
  logic                  last_bit;

  assign terminal    = (div_cnt == DIV_LAST);
  assign rise_ev     = terminal & ~sck;
  assign fall_ev     = terminal & sck;
  assign bit_cnt_nxt = bit_cnt + 6'd1;
  assign sd_sync     = sd_pipe[1];

  // Slot bit 0 is the WS-transition bit; the MSB sits in bit 1.
  assign in_slot  = (bit_cnt[5] == SLOT) && (bit_cnt[4:0] != 5'd0) &&
                    (bit_cnt[4:0] <= LAST_BIT);
  assign last_bit = (bit_cnt[4:0] == LAST_BIT);

  generate
    if (DATA_WIDTH == 1) begin : g_narrow
      assign shift_nxt = sd_sync;
    end else begin : g_wide
      assign shift_nxt = {shreg[DATA_WIDTH-2:0], sd_sync};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sck     <= 1'b0;
      bit_cnt <= '0;
      i2s_ws  <= 1'b0;
      sd_pipe <= '0;
      shreg   <= '0;
      pcm_out <= '0;
      ready   <= 1'b0;
    end else begin
      sd_pipe <= {sd_pipe[0], i2s_sd};
      ready   <= 1'b0;
      if (terminal) begin
        div_cnt <= '0;
        sck     <= ~sck;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (fall_ev) begin
        bit_cnt <= bit_cnt_nxt;
        i2s_ws  <= bit_cnt_nxt[5];
      end
      if (rise_ev && in_slot) begin
        shreg <= shift_nxt;
        if (last_bit) begin
          pcm_out <= shift_nxt;
          ready   <= 1'b1;
        end
      end
    end
  end

  assign i2s_clk = sck;

endmodule

// File: tb/tb_i2s_capture.sv
// Bench for i2s_capture: three instances (left, right, fast 24-bit) fed by
// I2S microphone models that push each sourced word to a scoreboard queue.
`timescale 1ns/1ps
module tb_i2s_capture;

  typedef struct {
    int          at;
    logic [31:0] val;
  } evt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sd = 1'b0;
  logic sd_p = 1'b0;

  logic        sck_l, ws_l, rdy_l;
  logic [15:0] pcm_l;
  logic        sck_r, ws_r, rdy_r;
  logic [15:0] pcm_r;
  logic        sck_p, ws_p, rdy_p;
  logic [23:0] pcm_p;

  int total = 0;
  int bad = 0;
  int ecnt = 0;
  int stable_err = 0;

  evt_t        got_l[$], got_r[$], got_p[$];
  logic [31:0] exp_l[$], exp_r[$], exp_p[$];
  logic [31:0] seq_l[$];
  logic [31:0] word_l = 32'h0, word_r = 32'h0, word_p = 32'h0;
  int          sck_rise[$], sck_fall[$], ws_rise[$], ws_fall[$], sckp_rise[$];

  always #5 clk = ~clk;

  i2s_capture u_l (
    .clk(clk), .rst_n(rst_n), .i2s_clk(sck_l), .i2s_ws(ws_l),
    .i2s_sd(sd), .pcm_out(pcm_l), .ready(rdy_l)
  );
  i2s_capture #(.CHANNEL(1)) u_r (
    .clk(clk), .rst_n(rst_n), .i2s_clk(sck_r), .i2s_ws(ws_r),
    .i2s_sd(sd), .pcm_out(pcm_r), .ready(rdy_r)
  );
  i2s_capture #(.SCK_HALF_PERIOD(4), .DATA_WIDTH(24)) u_p (
    .clk(clk), .rst_n(rst_n), .i2s_clk(sck_p), .i2s_ws(ws_p),
    .i2s_sd(sd_p), .pcm_out(pcm_p), .ready(rdy_p)
  );

  // edge 1 = first rising clk with rst_n high
  always @(posedge clk) begin
    if (!rst_n) ecnt = 0;
    else ecnt = ecnt + 1;
  end

  logic        p_sck_l = 1'b0, p_ws_l = 1'b0, p_sck_p = 1'b0, p_rst = 1'b0;
  logic [15:0] p_pcm_l = '0, p_pcm_r = '0;
  logic [23:0] p_pcm_p = '0;

  always @(negedge clk) begin
    evt_t e;
    e.at = ecnt;
    if (rdy_l) begin e.val = 32'(pcm_l); got_l.push_back(e); end
    if (rdy_r) begin e.val = 32'(pcm_r); got_r.push_back(e); end
    if (rdy_p) begin e.val = 32'(pcm_p); got_p.push_back(e); end
    if (rst_n) begin
      if (sck_l && !p_sck_l) sck_rise.push_back(ecnt);
      if (!sck_l && p_sck_l) sck_fall.push_back(ecnt);
      if (ws_l && !p_ws_l) ws_rise.push_back(ecnt);
      if (!ws_l && p_ws_l) ws_fall.push_back(ecnt);
      if (sck_p && !p_sck_p) sckp_rise.push_back(ecnt);
      if (p_rst && !rdy_l && pcm_l !== p_pcm_l) stable_err++;
      if (p_rst && !rdy_r && pcm_r !== p_pcm_r) stable_err++;
      if (p_rst && !rdy_p && pcm_p !== p_pcm_p) stable_err++;
    end
    p_sck_l = sck_l; p_ws_l = ws_l; p_sck_p = sck_p; p_rst = rst_n;
    p_pcm_l = pcm_l; p_pcm_r = pcm_r; p_pcm_p = pcm_p;
  end

  // Mic: bit b of a slot is the word MSB-first for b=1..dw; left pad 1s, right pad 0s.
  task automatic mic_bit(input int fc, input logic [31:0] lw, input logic [31:0] rw,
                         input int dw, output logic v);
    int bc, b;
    logic [31:0] w;
    bc = fc % 64;
    b  = bc % 32;
    w  = (bc < 32) ? lw : rw;
    if (b >= 1 && b <= dw) v = w[dw-b];
    else v = (bc < 32);
  endtask

  initial begin : mic_main
    int fc;
    logic v;
    fc = 0;
    forever begin
      @(negedge sck_l or negedge rst_n);
      if (!rst_n) fc = 0;
      else begin
        fc++;
        if (fc % 64 == 1) begin
          if (seq_l.size() > 0) word_l = seq_l.pop_front();
          exp_l.push_back(word_l);
        end
        if (fc % 64 == 33) exp_r.push_back(word_r);
      end
      mic_bit(fc, word_l, word_r, 16, v);
      sd = v;
    end
  end

  initial begin : mic_fast
    int fc;
    logic v;
    fc = 0;
    forever begin
      @(negedge sck_p or negedge rst_n);
      if (!rst_n) fc = 0;
      else begin
        fc++;
        if (fc % 64 == 1) exp_p.push_back(word_p);
      end
      mic_bit(fc, word_p, 32'h0, 24, v);
      sd_p = v;
    end
  end

  task automatic clear_all();
    got_l.delete(); got_r.delete(); got_p.delete();
    exp_l.delete(); exp_r.delete(); exp_p.delete();
    sck_rise.delete(); sck_fall.delete(); ws_rise.delete(); ws_fall.delete();
    sckp_rise.delete();
    stable_err = 0;
  endtask

  task automatic run_to(input int n);
    while (ecnt < n) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_all();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if ({sck_l, ws_l, rdy_l, pcm_l} !== '0) begin
        bad++; $display("FAIL reset_l cyc%0d got=%0h exp=0", i, {sck_l, ws_l, rdy_l, pcm_l});
      end
      total++;
      if ({sck_r, ws_r, rdy_r, pcm_r} !== '0) begin
        bad++; $display("FAIL reset_r cyc%0d got=%0h exp=0", i, {sck_r, ws_r, rdy_r, pcm_r});
      end
      total++;
      if ({sck_p, ws_p, rdy_p, pcm_p} !== '0) begin
        bad++; $display("FAIL reset_p cyc%0d got=%0h exp=0", i, {sck_p, ws_p, rdy_p, pcm_p});
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clocks();
    int per_bad;
    run_to(2100);
    total++;
    if (sck_rise.size() < 2 || sck_fall.size() < 1) begin
      bad++; $display("FAIL sck_edges got=%0d exp>=2", sck_rise.size());
    end else begin
      total++;
      if (sck_rise[0] !== 16) begin bad++; $display("FAIL sck_first_rise got=%0d exp=16", sck_rise[0]); end
      total++;
      if (sck_fall[0] !== 32) begin bad++; $display("FAIL sck_first_fall got=%0d exp=32", sck_fall[0]); end
      per_bad = 0;
      for (int i = 1; i < sck_rise.size(); i++)
        if (sck_rise[i] - sck_rise[i-1] != 32) per_bad++;
      total++;
      if (per_bad !== 0) begin bad++; $display("FAIL sck_period bad_periods=%0d exp=0", per_bad); end
    end
    total++;
    if (ws_rise.size() < 1 || ws_fall.size() < 1) begin
      bad++; $display("FAIL ws_edges got=%0d/%0d exp=1/1", ws_rise.size(), ws_fall.size());
    end else begin
      total++;
      if (ws_rise[0] !== 1024) begin bad++; $display("FAIL ws_rise got=%0d exp=1024", ws_rise[0]); end
      total++;
      if (ws_fall[0] !== 2048) begin bad++; $display("FAIL ws_fall got=%0d exp=2048", ws_fall[0]); end
    end
  endtask

  task automatic test_left();
    int n;
    run_to(5000);
    n = got_l.size();
    total++;
    if (n !== 3) begin bad++; $display("FAIL left_count got=%0d exp=3", n); end
    for (int i = 0; i < n; i++) begin
      evt_t g;
      logic [31:0] x;
      g = got_l.pop_front();
      x = (exp_l.size() > 0) ? exp_l.pop_front() : 32'hDEAD_BEEF;
      total++;
      if (g.val !== x || x !== 32'hA5C3) begin
        bad++; $display("FAIL left_val%0d got=%0h exp=%0h", i, g.val, x);
      end
      total++;
      if (g.at !== 528 + 2048*i) begin bad++; $display("FAIL left_time%0d got=%0d exp=%0d", i, g.at, 528 + 2048*i); end
    end
  endtask

  task automatic test_right();
    int n;
    n = got_r.size();
    total++;
    if (n !== 2) begin bad++; $display("FAIL right_count got=%0d exp=2", n); end
    for (int i = 0; i < n; i++) begin
      evt_t g;
      logic [31:0] x;
      g = got_r.pop_front();
      x = (exp_r.size() > 0) ? exp_r.pop_front() : 32'hDEAD_BEEF;
      total++;
      if (g.val !== x || x !== 32'h1234) begin
        bad++; $display("FAIL right_val%0d got=%0h exp=%0h", i, g.val, x);
      end
      total++;
      if (g.at !== 1552 + 2048*i) begin bad++; $display("FAIL right_time%0d got=%0d exp=%0d", i, g.at, 1552 + 2048*i); end
    end
  endtask

  task automatic test_sweep();
    int n;
    total++;
    if (sckp_rise.size() < 2) begin
      bad++; $display("FAIL fast_sck_edges got=%0d exp>=2", sckp_rise.size());
    end else begin
      total++;
      if (sckp_rise[0] !== 4) begin bad++; $display("FAIL fast_sck_rise got=%0d exp=4", sckp_rise[0]); end
      total++;
      if (sckp_rise[1] - sckp_rise[0] !== 8) begin
        bad++; $display("FAIL fast_sck_period got=%0d exp=8", sckp_rise[1] - sckp_rise[0]);
      end
    end
    n = got_p.size();
    total++;
    if (n !== 10) begin bad++; $display("FAIL fast_count got=%0d exp=10", n); end
    for (int i = 0; i < n; i++) begin
      evt_t g;
      logic [31:0] x;
      g = got_p.pop_front();
      x = (exp_p.size() > 0) ? exp_p.pop_front() : 32'hDEAD_BEEF;
      total++;
      if (g.val !== x || x !== 32'hC0FFEE || g.at !== 196 + 512*i) begin
        bad++; $display("FAIL fast_sample%0d got=%0h@%0d exp=%0h@%0d", i, g.val, g.at, x, 196 + 512*i);
      end
    end
    total++;
    if (stable_err !== 0) begin bad++; $display("FAIL pcm_stable got=%0d exp=0", stable_err); end
  endtask

  task automatic test_reset_mid();
    run_to(6420);  // inside left bit 8 of the fourth frame
    total++;
    if (got_l.size() !== 0) begin bad++; $display("FAIL mid_pre_ready got=%0d exp=0", got_l.size()); end
    word_l = 32'h3C5A;
    rst_n = 1'b0;
    clear_all();
    @(posedge clk); @(negedge clk);
    total++;
    if ({sck_l, ws_l, rdy_l, pcm_l} !== '0) begin
      bad++; $display("FAIL mid_reset_out got=%0h exp=0", {sck_l, ws_l, rdy_l, pcm_l});
    end
    rst_n = 1'b1;
    run_to(600);
    total++;
    if (sck_rise.size() < 1 || sck_rise[0] !== 16) begin
      bad++; $display("FAIL mid_sck_restart got=%0d exp=16", (sck_rise.size() > 0) ? sck_rise[0] : -1);
    end
    total++;
    if (got_l.size() !== 1) begin
      bad++; $display("FAIL mid_count got=%0d exp=1", got_l.size());
    end else begin
      evt_t g;
      logic [31:0] x;
      g = got_l.pop_front();
      x = (exp_l.size() > 0) ? exp_l.pop_front() : 32'hDEAD_BEEF;
      total++;
      if (g.val !== x || x !== 32'h3C5A || g.at !== 528) begin
        bad++; $display("FAIL mid_sample got=%0h@%0d exp=%0h@528", g.val, g.at, x);
      end
    end
  endtask

  task automatic test_sequence();
    logic [31:0] want[4];
    int n;
    want[0] = 32'h8000; want[1] = 32'h7FFF; want[2] = 32'hFFFF; want[3] = 32'h0000;
    @(negedge clk);
    rst_n = 1'b0;
    clear_all();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) seq_l.push_back(want[i]);
    rst_n = 1'b1;
    run_to(7000);
    n = got_l.size();
    total++;
    if (n !== 4) begin bad++; $display("FAIL seq_count got=%0d exp=4", n); end
    for (int i = 0; i < n && i < 4; i++) begin
      evt_t g;
      logic [31:0] x;
      g = got_l.pop_front();
      x = (exp_l.size() > 0) ? exp_l.pop_front() : 32'hDEAD_BEEF;
      total++;
      if (g.val !== x || x !== want[i] || g.at !== 528 + 2048*i) begin
        bad++; $display("FAIL seq_sample%0d got=%0h@%0d exp=%0h@%0d", i, g.val, g.at, x, 528 + 2048*i);
      end
    end
    total++;
    if (stable_err !== 0) begin bad++; $display("FAIL seq_pcm_stable got=%0d exp=0", stable_err); end
  endtask

  initial begin
    word_l = 32'hA5C3;
    word_r = 32'h1234;
    word_p = 32'hC0FFEE;
    test_reset();
    test_clocks();
    test_left();
    test_right();
    test_sweep();
    test_reset_mid();
    test_sequence();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
